// File: rtl/sap_pkg.sv
// sap_pkg: shared constants for the SAP-1 control unit.
//   - Opcode values (IR upper nibble): OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT.
//   - Control-word bit indices CW_CP..CW_LO. The word is packed as
//     {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}, so cp is bit 11.
//   - One-hot T-state constants T1..T6 (bit0 = T1).
//   - Named control words for the fetch cycle and for each instruction's
//     execute states.
package sap_pkg;

    localparam int OP_WIDTH = 4;
    localparam int CW_WIDTH = 12;
    localparam int T_WIDTH  = 6;

    localparam logic [OP_WIDTH-1:0] OP_LDA = 4'h0;
    localparam logic [OP_WIDTH-1:0] OP_ADD = 4'h1;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 4'h2;
    localparam logic [OP_WIDTH-1:0] OP_OUT = 4'hE;
    localparam logic [OP_WIDTH-1:0] OP_HLT = 4'hF;

    localparam int CW_CP = 11;  // increment PC
    localparam int CW_EP = 10;  // PC drives bus
    localparam int CW_LM = 9;   // load MAR
    localparam int CW_CE = 8;   // RAM drives bus
    localparam int CW_LI = 7;   // load IR
    localparam int CW_EI = 6;   // IR operand drives bus
    localparam int CW_LA = 5;   // load A
    localparam int CW_EA = 4;   // A drives bus
    localparam int CW_SU = 3;   // ALU subtract
    localparam int CW_EU = 2;   // ALU drives bus
    localparam int CW_LB = 1;   // load B
    localparam int CW_LO = 0;   // load output register

    localparam logic [T_WIDTH-1:0] T1 = 6'b000001;
    localparam logic [T_WIDTH-1:0] T2 = 6'b000010;
    localparam logic [T_WIDTH-1:0] T3 = 6'b000100;
    localparam logic [T_WIDTH-1:0] T4 = 6'b001000;
    localparam logic [T_WIDTH-1:0] T5 = 6'b010000;
    localparam logic [T_WIDTH-1:0] T6 = 6'b100000;

    localparam logic [CW_WIDTH-1:0] CW_NONE   = '0;
    localparam logic [CW_WIDTH-1:0] CW_FETCH1 = 12'(1 << CW_EP) | 12'(1 << CW_LM);  // 600
    localparam logic [CW_WIDTH-1:0] CW_FETCH2 = 12'(1 << CW_CP);                     // 800
    localparam logic [CW_WIDTH-1:0] CW_FETCH3 = 12'(1 << CW_CE) | 12'(1 << CW_LI);  // 180
    // Operand address from IR into MAR, shared by LDA/ADD/SUB in T4.
    localparam logic [CW_WIDTH-1:0] CW_MEM_ADDR = 12'(1 << CW_LM) | 12'(1 << CW_EI); // 240
    localparam logic [CW_WIDTH-1:0] CW_LDA_T5 = 12'(1 << CW_CE) | 12'(1 << CW_LA);  // 120
    localparam logic [CW_WIDTH-1:0] CW_ALU_T5 = 12'(1 << CW_CE) | 12'(1 << CW_LB);  // 102
    localparam logic [CW_WIDTH-1:0] CW_ADD_T6 = 12'(1 << CW_LA) | 12'(1 << CW_EU);  // 024
    localparam logic [CW_WIDTH-1:0] CW_SUB_T6 = CW_ADD_T6 | 12'(1 << CW_SU);        // 02C
    localparam logic [CW_WIDTH-1:0] CW_OUT_T4 = 12'(1 << CW_EA) | 12'(1 << CW_LO);  // 011

endpackage

// File: rtl/sap_controller_sequencer_if.sv
// sap_controller_sequencer_if: bundle between the instruction register side
// and the SAP-1 control unit.
//   opcode  : IR[7:4], driven by the master (IR side)
//   t_state : one-hot ring state, bit0 = T1, driven by the slave (controller)
//   cw      : 12-bit control word {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
//   hlt     : registered halt flag
interface sap_controller_sequencer_if;
    import sap_pkg::*;

    logic [OP_WIDTH-1:0] opcode;
    logic [T_WIDTH-1:0]  t_state;
    logic [CW_WIDTH-1:0] cw;
    logic                hlt;

    modport master (
        output opcode,
        input  t_state,
        input  cw,
        input  hlt
    );

    modport slave (
        input  opcode,
        output t_state,
        output cw,
        output hlt
    );

endinterface

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: 6-bit one-hot ring counter T1 -> T2 -> ... -> T6 -> T1.
//   clk     in  1  step pulse or free-running clock; advances on posedge
//   reset   in  1  asynchronous active-high, forces T1
//   hold    in  1  freezes the ring at its current state
//   t_state out 6  one-hot state, bit0 = T1
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    output logic [T_WIDTH-1:0] t_state
);

    logic [T_WIDTH-1:0] t_state_reg;
    logic [T_WIDTH-1:0] t_state_next;

    // Rotate left by one: bit gi takes the value of the previous bit, and
    // T1 takes the value of T6 so the ring wraps.
    generate
        for (genvar gi = 0; gi < T_WIDTH; gi++) begin : g_rotate
            assign t_state_next[gi] = t_state_reg[(gi + T_WIDTH - 1) % T_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_state_reg <= T1;
        end else if (!hold) begin
            t_state_reg <= t_state_next;
        end
    end

    assign t_state = t_state_reg;

endmodule

// File: rtl/sap_controller_sequencer.sv
// sap_controller_sequencer: SAP-1 control unit.
// Decodes the IR opcode together with the current T-state into the 12-bit
// control word that gates every load/enable on the W bus.
//   clk   in   1  sole clock (single-step one-shot or free-running)
//   reset in   1  asynchronous active-high; forces T1 and clears hlt
//   bus   slave  opcode in, t_state/cw/hlt out (sap_controller_sequencer_if)
// cw is purely combinational from (t_state, opcode).
// Optional feature macro SAP_HLT_EN: when defined, opcode 4'hF in T4 halts
// the machine (hlt=1, ring frozen at T4, cw=0) until reset. When undefined,
// 4'hF decodes as a NOP and hlt is tied low.
module sap_controller_sequencer
    import sap_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    sap_controller_sequencer_if.slave    bus
);

    logic [T_WIDTH-1:0]  t_state;
    logic [CW_WIDTH-1:0] cw_next;
    logic [CW_WIDTH-1:0] cw_decode;
    logic                hold;
    logic                hlt_reg;

    sap_ring_counter u_ring (
        .clk     (clk),
        .reset   (reset),
        .hold    (hold),
        .t_state (t_state)
    );

    // Fetch is common to all opcodes; execute words depend on the opcode.
    // Unlisted opcodes fall through to zero, which makes them NOPs while
    // the ring keeps running.
    always_comb begin
        cw_decode = CW_NONE;
        case (t_state)
            T1: cw_decode = CW_FETCH1;
            T2: cw_decode = CW_FETCH2;
            T3: cw_decode = CW_FETCH3;
            T4: begin
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB: cw_decode = CW_MEM_ADDR;
                    OP_OUT:                 cw_decode = CW_OUT_T4;
                    default:                cw_decode = CW_NONE;
                endcase
            end
            T5: begin
                case (bus.opcode)
                    OP_LDA:         cw_decode = CW_LDA_T5;
                    OP_ADD, OP_SUB: cw_decode = CW_ALU_T5;
                    default:        cw_decode = CW_NONE;
                endcase
            end
            T6: begin
                case (bus.opcode)
                    OP_ADD:  cw_decode = CW_ADD_T6;
                    OP_SUB:  cw_decode = CW_SUB_T6;
                    default: cw_decode = CW_NONE;
                endcase
            end
            default: cw_decode = CW_NONE;
        endcase
    end

`ifdef SAP_HLT_EN
    logic halt_now;

    // The halting edge itself must not advance the ring, so hold is raised
    // combinationally in T4 before hlt_reg is set.
    assign halt_now = (t_state == T4) && (bus.opcode == OP_HLT);
    assign hold     = hlt_reg | halt_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hlt_reg <= 1'b0;
        end else if (halt_now) begin
            hlt_reg <= 1'b1;
        end
    end

    // Once halted the IR may still change; keep the bus quiet regardless.
    assign cw_next = hlt_reg ? CW_NONE : cw_decode;
`else
    assign hlt_reg = 1'b0;
    assign hold    = 1'b0;
    assign cw_next = cw_decode;
`endif

    assign bus.t_state = t_state;
    assign bus.cw      = cw_next;
    assign bus.hlt     = hlt_reg;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Randomized scoreboard bench for sap_controller_sequencer.
// Stimulus pushes the reference model's expected (t_state, cw, hlt) for each
// cycle into a queue; an independent monitor pops and compares on negedge.
module tb_sap_controller_sequencer;

`ifdef SAP_HLT_EN
    localparam bit HLT_EN = 1'b1;
`else
    localparam bit HLT_EN = 1'b0;
`endif

    logic clk;
    logic reset;

    sap_controller_sequencer_if bus_if ();

    sap_controller_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          txn;
        logic [3:0]  op;
        logic [5:0]  t_state;
        logic [11:0] cw;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int txn_cnt = 0;

    // Reference model: step is the T-state index 0..5, halted is the hlt flag.
    int m_step = 0;
    bit m_hlt  = 1'b0;

    // Execute words per instruction for T4, T5, T6, straight from the
    // instruction table.
    function automatic logic [11:0] model_cw(input int step, input logic [3:0] op, input bit halted);
        logic [11:0] exec_w [3];
        if (halted) return 12'h000;
        if (step == 0) return 12'h600;
        if (step == 1) return 12'h800;
        if (step == 2) return 12'h180;
        case (op)
            4'h0:    exec_w = '{12'h240, 12'h120, 12'h000};
            4'h1:    exec_w = '{12'h240, 12'h102, 12'h024};
            4'h2:    exec_w = '{12'h240, 12'h102, 12'h02C};
            4'hE:    exec_w = '{12'h011, 12'h000, 12'h000};
            default: exec_w = '{12'h000, 12'h000, 12'h000};
        endcase
        return exec_w[step - 3];
    endfunction

    task automatic push_expect(input logic [3:0] op);
        exp_t e;
        e.txn     = txn_cnt;
        e.op      = op;
        e.t_state = 6'(1 << m_step);
        e.cw      = model_cw(m_step, op, m_hlt);
        e.hlt     = m_hlt;
        exp_q.push_back(e);
        txn_cnt++;
    endtask

    task automatic model_edge(input logic [3:0] op);
        if (m_hlt) begin
            m_step = m_step;
        end else if (HLT_EN && m_step == 3 && op == 4'hF) begin
            m_hlt = 1'b1;
        end else begin
            m_step = (m_step + 1) % 6;
        end
    endtask

    // Called #1 after a posedge: drive opcode, record the expectation for the
    // current state, then advance through one posedge.
    task automatic run_cycle(input logic [3:0] op);
        bus_if.opcode = op;
        push_expect(op);
        @(posedge clk);
        #1;
        model_edge(op);
    endtask

    task automatic run_instr(input logic [3:0] op);
        repeat (6) run_cycle(op);
    endtask

    task automatic run_to_t1(input logic [3:0] op);
        while (m_step != 0 && !m_hlt) run_cycle(op);
    endtask

    // Reset asserted at a random point inside the cycle; the monitor checks
    // the reset state on the following negedge, before any posedge.
    task automatic apply_reset();
        #($urandom_range(1, 3));
        reset  = 1'b1;
        m_step = 0;
        m_hlt  = 1'b0;
        push_expect(bus_if.opcode);
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_edge(bus_if.opcode);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                logic [11:0] cw_a;
                e = exp_q.pop_front();
                cw_a = bus_if.cw;
                $display("txn %0d op=%h t_state=%b cw=%h hlt=%b", e.txn, e.op, bus_if.t_state, cw_a, bus_if.hlt);
                checks++;
                if (bus_if.t_state !== e.t_state) begin
                    errors++;
                    $display("FAIL t_state txn=%0d got=%b want=%b", e.txn, bus_if.t_state, e.t_state);
                end
                checks++;
                if (cw_a !== e.cw) begin
                    errors++;
                    $display("FAIL cw txn=%0d got=%h want=%h", e.txn, cw_a, e.cw);
                end
                checks++;
                if (bus_if.hlt !== e.hlt) begin
                    errors++;
                    $display("FAIL hlt txn=%0d got=%b want=%b", e.txn, bus_if.hlt, e.hlt);
                end
                checks++;
                if ($countones({cw_a[10], cw_a[6], cw_a[4], cw_a[2]}) > 1) begin
                    errors++;
                    $display("FAIL bus_excl txn=%0d got cw=%h want at most one of ep/ei/ea/eu", e.txn, cw_a);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [3:0] op;
        reset         = 1'b1;
        bus_if.opcode = 4'h0;
        @(posedge clk);
        #1;
        apply_reset();
        run_to_t1(4'h0);

        // Directed: LDA twice, ADD, SUB, OUT, NOP(5)
        run_instr(4'h0);
        run_instr(4'h0);
        run_instr(4'h1);
        run_instr(4'h2);
        run_instr(4'hE);
        run_instr(4'h5);

        // Random whole instructions (no HLT)
        for (int i = 0; i < 20; i++) begin
            op = 4'($urandom_range(0, 14));
            run_instr(op);
        end

        // Reset while in T5 of ADD, then a clean fetch
        repeat (4) run_cycle(4'h1);
        apply_reset();
        run_to_t1(4'h0);
        run_instr(4'h0);

        // Opcode changing every cycle, including mid T4..T6
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 14));
            run_cycle(op);
        end
        run_to_t1(4'h0);

        // HLT: fetch + T4 with opcode F, then 10 cycles with random opcodes
        repeat (4) run_cycle(4'hF);
        for (int i = 0; i < 10; i++) begin
            op = 4'($urandom_range(0, 15));
            run_cycle(op);
        end
        apply_reset();
        run_to_t1(4'h0);
        run_instr(4'h1);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
